// File: rtl/fast_control_rx_pkg.sv
// Shared fast-control definitions, used by both the generator and this receiver.
//   FC_*           bit positions of the commands inside the decoded 8-bit word
//   lock_state_t   bunch-counter lock FSM states
//   fc_cmd_t       decoded command fields that the receiver acts on
//   sat_inc16      saturating +1 for the 16-bit statistics counters
package fast_control_pkg;

  localparam int FC_BCR          = 0;
  localparam int FC_L1A          = 1;
  localparam int FC_LINK_RESET   = 2;
  localparam int FC_BUFFER_CLEAR = 3;
  localparam int FC_CALIB        = 5;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_CHECKING = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

  typedef struct packed {
    logic calib;
    logic buffer_clear;
    logic link_reset;
    logic l1a;
    logic bcr;
  } fc_cmd_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fast_control_rx_if.sv
// Fast-control receiver bus.
//   master: drives the encoded stream, orbit length and counter clear; sees results
//   slave : the receiver; drives strobes, tags, lock status and statistics
interface fast_control_rx_if;
  logic [15:0] fc_stream_enc;
  logic [11:0] orb_length;
  logic        counter_clear;
  logic        bcr;
  logic        l1a;
  logic        link_reset;
  logic        buffer_clear;
  logic        calib_pulse;
  logic [11:0] l1a_bxid;
  logic [31:0] l1a_evtid;
  logic        locked;
  logic [11:0] bx_counter;
  logic [15:0] sbe_count;
  logic [15:0] dbe_count;
  logic [15:0] bcr_err_count;

  modport master (
    output fc_stream_enc, orb_length, counter_clear,
    input  bcr, l1a, link_reset, buffer_clear, calib_pulse, l1a_bxid, l1a_evtid,
           locked, bx_counter, sbe_count, dbe_count, bcr_err_count
  );

  modport slave (
    input  fc_stream_enc, orb_length, counter_clear,
    output bcr, l1a, link_reset, buffer_clear, calib_pulse, l1a_bxid, l1a_evtid,
           locked, bx_counter, sbe_count, dbe_count, bcr_err_count
  );
endinterface

// File: rtl/fast_control_rx_hamming84_dec.sv
// Hamming(8,4) SECDED decoder, combinational.
//   code[7:0] : codeword. [6:0] is Hamming(7,4) with bit i at position i+1
//               (p1,p2,d0,p4,d1,d2,d3); [7] is even parity over [6:0].
//   data[3:0] : corrected data nibble
//   sbe       : one bit was wrong and has been corrected
//   dbe       : two bits wrong, data is not trustworthy
module hamming84_dec (
  input  logic [7:0] code,
  output logic [3:0] data,
  output logic       sbe,
  output logic       dbe
);
  logic [2:0] syn;
  logic       par;
  logic [7:0] fixed;

  always_comb begin
    syn[0] = code[0] ^ code[2] ^ code[4] ^ code[6];
    syn[1] = code[1] ^ code[2] ^ code[5] ^ code[6];
    syn[2] = code[3] ^ code[4] ^ code[5] ^ code[6];
    par    = ^code;
    fixed  = code;
    // Odd overall parity means one flip; syndrome 0 then points at the parity bit itself.
    if (par && (syn != 3'd0)) fixed[syn - 3'd1] = ~code[syn - 3'd1];
    sbe  = par;
    dbe  = ~par & (syn != 3'd0);
    data = {fixed[6], fixed[5], fixed[4], fixed[2]};
  end
endmodule

// File: rtl/fast_control_rx.sv
// Fast-control receiver: corrects/decodes one Hamming-protected word per BX,
// issues command strobes, keeps a bunch counter locked to BCRs, tags L1As and
// counts link errors.
//   clk_bx, reset : BX clock, synchronous active-high reset
//   bus (slave)   : encoded stream in, orbit length, counter clear; strobes,
//                   L1A tags, lock status, bunch counter and statistics out
// Latency: word in cycle N -> strobes, bx_counter and sbe/dbe/bcr_err in N+2;
// locked in N+3.
module fast_control_rx
  import fast_control_pkg::*;
#(
  parameter int LOCK_COUNT = 4
) (
  input  logic              clk_bx,
  input  logic              reset,
  fast_control_rx_if.slave  bus
);
  localparam int GW = $clog2(LOCK_COUNT + 1);

  logic [15:0] enc_q;
  logic [3:0]  lo_data, hi_data;
  logic        lo_sbe, lo_dbe, hi_sbe, hi_dbe;
  logic        word_sbe, word_dbe;
  logic [7:0]  dec_word;
  fc_cmd_t     dec_cmd, cmd_q;
  logic        unused_word_bits;

  logic [11:0] bx_q, bx_next, orb_last, bxid_q;
  logic [31:0] evtid_q;
  logic [15:0] sbe_q, dbe_q, bcr_err_q;
  logic        at_last, bcr_expected, bcr_misplaced, bx_wrap;

  lock_state_t   state_q, state_d;
  logic [GW-1:0] good_q;
  logic          good_clr, good_inc, bcr_err_inc, locked_q;

  hamming84_dec u_dec_lo (.code(enc_q[7:0]),  .data(lo_data), .sbe(lo_sbe), .dbe(lo_dbe));
  hamming84_dec u_dec_hi (.code(enc_q[15:8]), .data(hi_data), .sbe(hi_sbe), .dbe(hi_dbe));

  // A word with any uncorrectable nibble is discarded whole; its single-bit
  // errors are then not counted separately.
  always_comb begin
    word_dbe = lo_dbe | hi_dbe;
    word_sbe = (lo_sbe | hi_sbe) & ~word_dbe;
    dec_word = word_dbe ? 8'h00 : {hi_data, lo_data};
    dec_cmd.bcr          = dec_word[FC_BCR];
    dec_cmd.l1a          = dec_word[FC_L1A];
    dec_cmd.link_reset   = dec_word[FC_LINK_RESET];
    dec_cmd.buffer_clear = dec_word[FC_BUFFER_CLEAR];
    dec_cmd.calib        = dec_word[FC_CALIB];
  end
  assign unused_word_bits = ^{dec_word[7:6], dec_word[4]};

  // Bunch counter runs one stage ahead of the command register so that a BCR
  // and the zeroed counter appear in the same output cycle.
  always_comb begin
    orb_last      = bus.orb_length - 12'd1;   // 0 -> 4095, i.e. a 4096-BX orbit
    at_last       = (bx_q == orb_last);
    bcr_expected  = dec_cmd.bcr & at_last;
    bcr_misplaced = dec_cmd.bcr & ~at_last;
    bx_wrap       = at_last & ~dec_cmd.bcr;
    bx_next       = (dec_cmd.bcr | at_last) ? 12'd0 : bx_q + 12'd1;
  end

  always_ff @(posedge clk_bx) begin
    if (reset) begin
      enc_q     <= '0;
      cmd_q     <= '0;
      bx_q      <= '0;
      bxid_q    <= '0;
      evtid_q   <= '0;
      sbe_q     <= '0;
      dbe_q     <= '0;
      bcr_err_q <= '0;
    end else begin
      enc_q <= bus.fc_stream_enc;
      cmd_q <= dec_cmd;
      bx_q  <= bx_next;
      if (dec_cmd.l1a) bxid_q <= bx_next;
      if (bus.counter_clear) begin
        evtid_q   <= '0;
        sbe_q     <= '0;
        dbe_q     <= '0;
        bcr_err_q <= '0;
      end else begin
        if (dec_cmd.l1a) evtid_q   <= evtid_q + 32'd1;
        if (word_sbe)    sbe_q     <= sat_inc16(sbe_q);
        if (word_dbe)    dbe_q     <= sat_inc16(dbe_q);
        if (bcr_err_inc) bcr_err_q <= sat_inc16(bcr_err_q);
      end
    end
  end

  // Lock FSM: state register
  always_ff @(posedge clk_bx) begin
    if (reset) begin
      state_q  <= ST_UNLOCKED;
      good_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      locked_q <= (state_q == ST_LOCKED);   // one cycle behind the decision
      if (good_clr)      good_q <= '0;
      else if (good_inc) good_q <= good_q + GW'(1);
    end
  end

  // Lock FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UNLOCKED: if (dec_cmd.bcr) state_d = ST_CHECKING;
      ST_CHECKING: begin
        if (bx_wrap) state_d = ST_UNLOCKED;
        else if (bcr_expected && (good_q == GW'(LOCK_COUNT - 1))) state_d = ST_LOCKED;
      end
      ST_LOCKED:   if (bcr_misplaced | bx_wrap) state_d = ST_CHECKING;
      default:     state_d = ST_UNLOCKED;
    endcase
  end

  // Lock FSM: outputs. Outside CHECKING the good count is held at 0 so it is
  // always fresh on entry.
  always_comb begin
    good_clr    = 1'b0;
    good_inc    = 1'b0;
    bcr_err_inc = 1'b0;
    case (state_q)
      ST_CHECKING: begin
        good_inc = bcr_expected;
        good_clr = bcr_misplaced;
      end
      ST_LOCKED: begin
        good_clr    = 1'b1;
        bcr_err_inc = bcr_misplaced | bx_wrap;
      end
      default: good_clr = 1'b1;
    endcase
  end

  assign bus.bcr           = cmd_q.bcr;
  assign bus.l1a           = cmd_q.l1a;
  assign bus.link_reset    = cmd_q.link_reset;
  assign bus.buffer_clear  = cmd_q.buffer_clear;
  assign bus.calib_pulse   = cmd_q.calib;
  assign bus.l1a_bxid      = bxid_q;
  assign bus.l1a_evtid     = evtid_q;
  assign bus.locked        = locked_q;
  assign bus.bx_counter    = bx_q;
  assign bus.sbe_count     = sbe_q;
  assign bus.dbe_count     = dbe_q;
  assign bus.bcr_err_count = bcr_err_q;
endmodule

// File: tb/tb_fast_control_rx.sv
// Bench for fast_control_rx: directed scenarios plus random traffic, every
// output compared each cycle against a behavioural model that works on the
// plain command word and on the number of flipped bits per byte.
module tb_fast_control_rx;
  localparam int LOCK = 4;
  localparam int M_UNL = 0, M_CHK = 1, M_LCK = 2;

  logic clk_bx = 1'b0;
  logic reset;
  always #5 clk_bx = ~clk_bx;

  fast_control_rx_if bus();
  fast_control_rx #(.LOCK_COUNT(LOCK)) dut (.clk_bx(clk_bx), .reset(reset), .bus(bus));

  int vectors = 0, miscompares = 0;
  int orb;

  // model state
  int          bx_m, good_m, mode_m, bxid_m, sbe_m, dbe_m, berr_m;
  bit          locked_m, bcr_m, l1a_m, lr_m, bc_m, cal_m;
  logic [31:0] evt_m;
  logic [7:0]  pend_w;
  int          pend_lo, pend_hi;

  function automatic logic [7:0] enc84(input logic [3:0] d);
    logic [6:0] c;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    c[0] = c[2] ^ c[4] ^ c[6];
    c[1] = c[2] ^ c[5] ^ c[6];
    c[3] = c[4] ^ c[5] ^ c[6];
    return {^c, c};
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // BCR belongs in the word presented now if it will emerge as the orbit wraps.
  function automatic bit bcr_due();
    int len;
    len = (orb == 0) ? 4096 : orb;
    return ((bx_m + 2) % len) == 0;
  endfunction

  function automatic logic [7:0] idle_word();
    return {7'h00, bcr_due()};
  endfunction

  function automatic logic [7:0] rand_flip(input int k);
    logic [7:0] m;
    m = 8'h00;
    for (int g = 0; g < 64 && $countones(m) < k; g++) m[$urandom_range(7)] = 1'b1;
    return m;
  endfunction

  task automatic model_edge(input bit rst, input bit clr);
    bit dbl, sgl, last, b;
    logic [7:0] eff;
    int lastpos;
    if (rst) begin
      bx_m = 0; good_m = 0; mode_m = M_UNL; bxid_m = 0; evt_m = 0;
      sbe_m = 0; dbe_m = 0; berr_m = 0; locked_m = 0;
      bcr_m = 0; l1a_m = 0; lr_m = 0; bc_m = 0; cal_m = 0;
    end else begin
      dbl = (pend_lo > 1) || (pend_hi > 1);
      sgl = !dbl && (pend_lo == 1 || pend_hi == 1);
      eff = dbl ? 8'h00 : pend_w;
      lastpos = (orb == 0) ? 4095 : orb - 1;
      last = (bx_m == lastpos);
      b = eff[0];
      locked_m = (mode_m == M_LCK);
      if (mode_m == M_UNL) begin
        if (b) begin mode_m = M_CHK; good_m = 0; end
      end else if (mode_m == M_CHK) begin
        if (b && last) begin
          good_m++;
          if (good_m == LOCK) mode_m = M_LCK;
        end else if (b) good_m = 0;
        else if (last) mode_m = M_UNL;
      end else begin
        if (b != last) begin mode_m = M_CHK; good_m = 0; berr_m = sat16(berr_m + 1); end
      end
      bx_m = (b || last) ? 0 : bx_m + 1;
      bcr_m = eff[0]; l1a_m = eff[1]; lr_m = eff[2]; bc_m = eff[3]; cal_m = eff[5];
      if (eff[1]) begin bxid_m = bx_m; evt_m = evt_m + 32'd1; end
      if (sgl) sbe_m = sat16(sbe_m + 1);
      if (dbl) dbe_m = sat16(dbe_m + 1);
      if (clr) begin evt_m = 0; sbe_m = 0; dbe_m = 0; berr_m = 0; end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("bcr",          32'(bus.bcr),           32'(bcr_m));
    check("l1a",          32'(bus.l1a),           32'(l1a_m));
    check("link_reset",   32'(bus.link_reset),    32'(lr_m));
    check("buffer_clear", 32'(bus.buffer_clear),  32'(bc_m));
    check("calib_pulse",  32'(bus.calib_pulse),   32'(cal_m));
    check("l1a_bxid",     32'(bus.l1a_bxid),      32'(bxid_m));
    check("l1a_evtid",    bus.l1a_evtid,          evt_m);
    check("locked",       32'(bus.locked),        32'(locked_m));
    check("bx_counter",   32'(bus.bx_counter),    32'(bx_m));
    check("sbe_count",    32'(bus.sbe_count),     32'(sbe_m));
    check("dbe_count",    32'(bus.dbe_count),     32'(dbe_m));
    check("bcr_err",      32'(bus.bcr_err_count), 32'(berr_m));
  endtask

  task automatic step(input logic [7:0] w, input logic [15:0] flip, input bit rst, input bit clr);
    bus.fc_stream_enc = {enc84(w[7:4]), enc84(w[3:0])} ^ flip;
    bus.counter_clear = clr;
    reset = rst;
    @(posedge clk_bx);
    model_edge(rst, clr);
    if (rst) begin
      pend_w = 8'h00; pend_lo = 0; pend_hi = 0;
    end else begin
      pend_w = w; pend_lo = $countones(flip[7:0]); pend_hi = $countones(flip[15:8]);
    end
    #1;
    check_all();
  endtask

  task automatic traffic(input int n, input int l1a_pct);
    logic [7:0] w;
    for (int i = 0; i < n; i++) begin
      w = 8'($urandom) & 8'hFC;
      if ($urandom_range(99) < l1a_pct) w[1] = 1'b1;
      w[0] = bcr_due();
      step(w, 16'h0000, 1'b0, 1'b0);
    end
  endtask

  task automatic noise(input int n);
    logic [7:0] w, fl, fh;
    int r;
    for (int i = 0; i < n; i++) begin
      w = 8'($urandom);
      w[0] = bcr_due();
      if ($urandom_range(99) < 8) w[0] = ~w[0];
      r = $urandom_range(99);
      fl = rand_flip((r < 80) ? 0 : (r < 92) ? 1 : 2);
      r = $urandom_range(99);
      fh = rand_flip((r < 80) ? 0 : (r < 92) ? 1 : 2);
      step(w, {fh, fl}, 1'b0, $urandom_range(99) < 3);
    end
  endtask

  task automatic wait_bx(input int target);
    for (int k = 0; k < 5000 && bx_m != target; k++) step(idle_word(), 16'h0, 1'b0, 1'b0);
    check("wait_bx", 32'(bus.bx_counter), 32'(target));
  endtask

  initial begin
    orb = 45;
    bus.orb_length = 12'd45;
    bus.counter_clear = 1'b0;
    bus.fc_stream_enc = '0;
    reset = 1'b1;

    // reset
    step(8'h00, 16'h0, 1'b1, 1'b0);
    step(8'h00, 16'h0, 1'b1, 1'b0);
    check("rst_bx", 32'(bus.bx_counter), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);

    // clean stream, BCR every 45 BX
    traffic(6 * 45, 20);
    check("clean_locked", 32'(bus.locked), 32'd1);
    check("clean_bcr_err", 32'(bus.bcr_err_count), 32'd0);

    // clear, then L1A emerging at BX 17
    step(idle_word(), 16'h0, 1'b0, 1'b1);
    wait_bx(15);
    step(8'h02, 16'h0, 1'b0, 1'b0);
    step(idle_word(), 16'h0, 1'b0, 1'b0);
    check("tag_l1a", 32'(bus.l1a), 32'd1);
    check("tag_bxid", 32'(bus.l1a_bxid), 32'd17);
    check("tag_evtid", bus.l1a_evtid, 32'd1);

    // single-bit error on a scheduled BCR
    wait_bx(43);
    step(8'h01, 16'h0008, 1'b0, 1'b0);
    step(idle_word(), 16'h0, 1'b0, 1'b0);
    check("sbe_bcr", 32'(bus.bcr), 32'd1);
    check("sbe_bx", 32'(bus.bx_counter), 32'd0);
    check("sbe_count", 32'(bus.sbe_count), 32'd1);

    // double-bit error drops an L1A
    wait_bx(10);
    step(8'h02, 16'h0006, 1'b0, 1'b0);
    step(idle_word(), 16'h0, 1'b0, 1'b0);
    check("dbe_l1a", 32'(bus.l1a), 32'd0);
    check("dbe_count", 32'(bus.dbe_count), 32'd1);
    check("dbe_evtid", bus.l1a_evtid, 32'd1);

    // misplaced BCR at BX 30 while locked
    check("mis_pre_locked", 32'(bus.locked), 32'd1);
    wait_bx(28);
    step(8'h01, 16'h0, 1'b0, 1'b0);
    step(idle_word(), 16'h0, 1'b0, 1'b0);
    check("mis_bcr", 32'(bus.bcr), 32'd1);
    check("mis_bx", 32'(bus.bx_counter), 32'd0);
    check("mis_bcr_err", 32'(bus.bcr_err_count), 32'd1);
    check("mis_locked_n2", 32'(bus.locked), 32'd1);
    step(idle_word(), 16'h0, 1'b0, 1'b0);
    check("mis_locked_n3", 32'(bus.locked), 32'd0);
    traffic(5 * 45, 20);
    check("relock", 32'(bus.locked), 32'd1);
    check("relock_bcr_err", 32'(bus.bcr_err_count), 32'd1);

    // reset in the middle of L1A traffic
    traffic(10, 100);
    step(8'h02, 16'h0, 1'b1, 1'b0);
    check("mrst_l1a", 32'(bus.l1a), 32'd0);
    check("mrst_bx", 32'(bus.bx_counter), 32'd0);
    check("mrst_evtid", bus.l1a_evtid, 32'd0);
    check("mrst_locked", 32'(bus.locked), 32'd0);
    step(8'h02, 16'h0, 1'b0, 1'b0);
    check("mrst_drop", 32'(bus.l1a), 32'd0);
    step(8'h02, 16'h0, 1'b0, 1'b0);
    check("mrst_refill", 32'(bus.l1a), 32'd1);
    check("mrst_refill_evt", bus.l1a_evtid, 32'd1);

    // short orbit with random noise, misplaced/missing BCRs and clears
    orb = 9;
    bus.orb_length = 12'd9;
    noise(400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
